// File: rtl/mips_pkg.sv
// Shared constants, ALU/forwarding enums and pipeline-register layouts for the
// 16-bit, five-stage MIPS-subset core.
package mips_pkg;

  localparam int unsigned PC_W   = 7;
  localparam int unsigned WORD_W = 16;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_e;
  typedef enum logic [1:0] {FWD_REG, FWD_EX_MEM, FWD_MEM_WB} fwd_sel_e;

  // All-zero contents of every stage register form a bubble
  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     instr;
  } if_id_t;

  typedef struct packed {
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              branch;
    logic              use_imm;
    alu_op_e           alu_op;
    logic [PC_W-1:0]   pc;
    logic [WORD_W-1:0] rs_val;
    logic [WORD_W-1:0] rt_val;
    logic [WORD_W-1:0] imm;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        dest;
  } id_ex_t;

  typedef struct packed {
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic [WORD_W-1:0] alu_res;
    logic [WORD_W-1:0] store_data;
    logic [4:0]        dest;
  } ex_mem_t;

  typedef struct packed {
    logic              reg_write;
    logic [WORD_W-1:0] wdata;
    logic [4:0]        dest;
  } mem_wb_t;

  function automatic logic [WORD_W-1:0] alu(input alu_op_e op,
                                            input logic [WORD_W-1:0] a,
                                            input logic [WORD_W-1:0] b);
    logic [WORD_W-1:0] r;
    r = '0;
    case (op)
      ALU_ADD: r = a + b;
      ALU_SUB: r = a - b;
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_SLT: r = {{(WORD_W-1){1'b0}}, ($signed(a) < $signed(b))};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mips_pipelined_cpu_hazard.sv
// Forwarding selects for the EX operands, load-use stall and branch flush.
module mips_hazard_unit
  import mips_pkg::*;
(
  input  logic     [4:0] ex_rs,
  input  logic     [4:0] ex_rt,
  input  logic           ex_mem_read,
  input  logic     [4:0] ex_dest,
  input  logic           exm_reg_write,
  input  logic     [4:0] exm_dest,
  input  logic           wb_reg_write,
  input  logic     [4:0] wb_dest,
  input  logic     [4:0] id_rs,
  input  logic     [4:0] id_rt,
  input  logic           id_uses_rs,
  input  logic           id_uses_rt,
  input  logic           branch_taken,
  output fwd_sel_e       fwd_a,
  output fwd_sel_e       fwd_b,
  output logic           stall,
  output logic           flush
);

  function automatic fwd_sel_e pick(input logic [4:0] src,
                                    input logic       m_we, input logic [4:0] m_dst,
                                    input logic       w_we, input logic [4:0] w_dst);
    fwd_sel_e s;
    s = FWD_REG;
    if (m_we && m_dst != '0 && m_dst == src)      s = FWD_EX_MEM;
    else if (w_we && w_dst != '0 && w_dst == src) s = FWD_MEM_WB;
    return s;
  endfunction

  logic load_use;

  always_comb begin
    fwd_a    = pick(ex_rs, exm_reg_write, exm_dest, wb_reg_write, wb_dest);
    fwd_b    = pick(ex_rt, exm_reg_write, exm_dest, wb_reg_write, wb_dest);
    load_use = ex_mem_read && ex_dest != '0 &&
               ((id_uses_rs && id_rs == ex_dest) || (id_uses_rt && id_rt == ex_dest));
    // A taken branch squashes the dependent instruction, so no stall is needed
    flush    = branch_taken;
    stall    = load_use && !branch_taken;
  end

endmodule

// File: rtl/mips_pipelined_cpu.sv
// Five-stage MIPS-subset core with inline instruction/data memories, host
// export ports usable while frozen (enPC=0), and an async active-low reset.
module mips_pipelined_cpu
  import mips_pkg::*;
#(
  parameter int unsigned IMEM_AW = 7,
  parameter int unsigned DMEM_AW = 11,
  parameter int unsigned DW      = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enPC,
  input  logic [IMEM_AW-1:0] instmem_export_address,
  input  logic [31:0]        instmem_export_data,
  input  logic               instmem_export_MW,
  input  logic               instmem_export_MR,
  output logic [31:0]        instmem_export_out,
  input  logic [DMEM_AW-1:0] datamem_export_address,
  input  logic [DW-1:0]      datamem_export_data,
  input  logic               datamem_export_MW,
  input  logic               datamem_export_MR,
  output logic [DW-1:0]      datamem_export_out
);

  logic [31:0]        imem [2**IMEM_AW];
  logic [DW-1:0]      dmem [2**DMEM_AW];
  logic [DW-1:0]      rf_q [32];

  logic [IMEM_AW-1:0] pc_q, pc_d;
  if_id_t             if_id_q, if_id_d;
  id_ex_t             id_ex_q, id_ex_d;
  ex_mem_t            ex_mem_q, ex_mem_d;
  mem_wb_t            mem_wb_q, mem_wb_d;

  assign instmem_export_out = instmem_export_MR ? imem[instmem_export_address] : '0;
  assign datamem_export_out = datamem_export_MR ? dmem[datamem_export_address] : '0;

  always_ff @(posedge clk) begin
    if (!enPC && instmem_export_MW) imem[instmem_export_address] <= instmem_export_data;
  end

  always_ff @(posedge clk) begin
    if (!enPC && datamem_export_MW)
      dmem[datamem_export_address] <= datamem_export_data;
    else if (enPC && ex_mem_q.mem_write)
      dmem[ex_mem_q.alu_res[DMEM_AW-1:0]] <= ex_mem_q.store_data;
  end

  // ---------------- ID: decode and register read ----------------
  logic [5:0] id_op, id_fn;
  logic [4:0] id_rs, id_rt, id_rd, id_sh;
  id_ex_t     id_dec;
  logic       id_uses_rs, id_uses_rt;

  assign id_op = if_id_q.instr[31:26];
  assign id_rs = if_id_q.instr[25:21];
  assign id_rt = if_id_q.instr[20:16];
  assign id_rd = if_id_q.instr[15:11];
  assign id_sh = if_id_q.instr[10:6];
  assign id_fn = if_id_q.instr[5:0];

  always_comb begin
    id_dec     = '0;
    id_uses_rs = 1'b0;
    id_uses_rt = 1'b0;
    id_dec.pc  = if_id_q.pc;
    id_dec.rs  = id_rs;
    id_dec.rt  = id_rt;
    id_dec.imm = if_id_q.instr[15:0];
    // Write-first register file: a same-cycle WB write is visible here
    id_dec.rs_val = (mem_wb_q.reg_write && mem_wb_q.dest != '0 && mem_wb_q.dest == id_rs)
                    ? mem_wb_q.wdata : rf_q[id_rs];
    id_dec.rt_val = (mem_wb_q.reg_write && mem_wb_q.dest != '0 && mem_wb_q.dest == id_rt)
                    ? mem_wb_q.wdata : rf_q[id_rt];
    case (id_op)
      OP_RTYPE: begin
        id_dec.dest      = id_rd;
        id_dec.reg_write = (id_sh == '0);
        case (id_fn)
          FN_ADD:  id_dec.alu_op = ALU_ADD;
          FN_SUB:  id_dec.alu_op = ALU_SUB;
          FN_AND:  id_dec.alu_op = ALU_AND;
          FN_OR:   id_dec.alu_op = ALU_OR;
          FN_SLT:  id_dec.alu_op = ALU_SLT;
          default: id_dec.reg_write = 1'b0;
        endcase
        id_uses_rs = id_dec.reg_write;
        id_uses_rt = id_dec.reg_write;
      end
      OP_ADDI: begin
        id_dec.reg_write = 1'b1;
        id_dec.use_imm   = 1'b1;
        id_dec.dest      = id_rt;
        id_uses_rs       = 1'b1;
      end
      OP_LW: begin
        id_dec.reg_write = 1'b1;
        id_dec.mem_read  = 1'b1;
        id_dec.use_imm   = 1'b1;
        id_dec.dest      = id_rt;
        id_uses_rs       = 1'b1;
      end
      OP_SW: begin
        id_dec.mem_write = 1'b1;
        id_dec.use_imm   = 1'b1;
        id_uses_rs       = 1'b1;
        id_uses_rt       = 1'b1;
      end
      OP_BEQ: begin
        id_dec.branch = 1'b1;
        id_uses_rs    = 1'b1;
        id_uses_rt    = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------- EX: forwarding, ALU, branch resolve ----------------
  fwd_sel_e           fwd_a, fwd_b;
  logic               stall, flush, branch_taken;
  logic [DW-1:0]      ex_a, ex_b_reg, ex_b;
  logic [IMEM_AW-1:0] branch_target;

  mips_hazard_unit u_hazard (
    .ex_rs         (id_ex_q.rs),
    .ex_rt         (id_ex_q.rt),
    .ex_mem_read   (id_ex_q.mem_read),
    .ex_dest       (id_ex_q.dest),
    .exm_reg_write (ex_mem_q.reg_write),
    .exm_dest      (ex_mem_q.dest),
    .wb_reg_write  (mem_wb_q.reg_write),
    .wb_dest       (mem_wb_q.dest),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_uses_rs    (id_uses_rs),
    .id_uses_rt    (id_uses_rt),
    .branch_taken  (branch_taken),
    .fwd_a         (fwd_a),
    .fwd_b         (fwd_b),
    .stall         (stall),
    .flush         (flush)
  );

  always_comb begin
    ex_a = id_ex_q.rs_val;
    case (fwd_a)
      FWD_EX_MEM: ex_a = ex_mem_q.alu_res;
      FWD_MEM_WB: ex_a = mem_wb_q.wdata;
      default:    ;
    endcase
    ex_b_reg = id_ex_q.rt_val;
    case (fwd_b)
      FWD_EX_MEM: ex_b_reg = ex_mem_q.alu_res;
      FWD_MEM_WB: ex_b_reg = mem_wb_q.wdata;
      default:    ;
    endcase
    ex_b          = id_ex_q.use_imm ? id_ex_q.imm : ex_b_reg;
    branch_taken  = id_ex_q.branch && (ex_a == ex_b_reg);
    branch_target = id_ex_q.pc + IMEM_AW'(1) + id_ex_q.imm[IMEM_AW-1:0];
  end

  // ---------------- next-state for PC and stage registers ----------------
  always_comb begin
    pc_d     = pc_q;
    if_id_d  = if_id_q;
    id_ex_d  = id_ex_q;
    ex_mem_d = ex_mem_q;
    mem_wb_d = mem_wb_q;
    if (enPC) begin
      ex_mem_d.reg_write  = id_ex_q.reg_write;
      ex_mem_d.mem_read   = id_ex_q.mem_read;
      ex_mem_d.mem_write  = id_ex_q.mem_write;
      ex_mem_d.alu_res    = alu(id_ex_q.alu_op, ex_a, ex_b);
      ex_mem_d.store_data = ex_b_reg;
      ex_mem_d.dest       = id_ex_q.dest;
      mem_wb_d.reg_write  = ex_mem_q.reg_write;
      mem_wb_d.dest       = ex_mem_q.dest;
      mem_wb_d.wdata      = ex_mem_q.mem_read ? dmem[ex_mem_q.alu_res[DMEM_AW-1:0]]
                                              : ex_mem_q.alu_res;
      if (flush) begin
        pc_d    = branch_target;
        if_id_d = '0;
        id_ex_d = '0;
      end else if (stall) begin
        id_ex_d = '0;
      end else begin
        pc_d          = pc_q + IMEM_AW'(1);
        if_id_d.pc    = pc_q;
        if_id_d.instr = imem[pc_q];
        id_ex_d       = id_dec;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q     <= '0;
      if_id_q  <= '0;
      id_ex_q  <= '0;
      ex_mem_q <= '0;
      mem_wb_q <= '0;
    end else begin
      pc_q     <= pc_d;
      if_id_q  <= if_id_d;
      id_ex_q  <= id_ex_d;
      ex_mem_q <= ex_mem_d;
      mem_wb_q <= mem_wb_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (enPC && mem_wb_q.reg_write && mem_wb_q.dest != '0) begin
      rf_q[mem_wb_q.dest] <= mem_wb_q.wdata;
    end
  end

endmodule

// File: tb/tb_mips_pipelined_cpu.sv
// Directed self-checking bench: host upload/readback, load-use, forwarding,
// branch flush, freeze and mid-run reset.
module tb_mips_pipelined_cpu;

  logic        clk = 1'b0;
  logic        rst, enPC;
  logic [6:0]  ia;
  logic [31:0] idat, iout;
  logic        imw, imr;
  logic [10:0] da;
  logic [15:0] ddat, dout;
  logic        dmw, dmr;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [31:0] prog [16];
  logic [15:0] rd16;

  always #5 clk = ~clk;

  mips_pipelined_cpu #(.IMEM_AW(7), .DMEM_AW(11), .DW(16)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .enPC                   (enPC),
    .instmem_export_address (ia),
    .instmem_export_data    (idat),
    .instmem_export_MW      (imw),
    .instmem_export_MR      (imr),
    .instmem_export_out     (iout),
    .datamem_export_address (da),
    .datamem_export_data    (ddat),
    .datamem_export_MW      (dmw),
    .datamem_export_MR      (dmr),
    .datamem_export_out     (dout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'b000000, rs, rt, rd, 5'b00000, fn};
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic imem_wr(input logic [6:0] a, input logic [31:0] d);
    ia = a; idat = d; imw = 1'b1;
    step(1);
    imw = 1'b0;
  endtask

  task automatic dmem_wr(input logic [10:0] a, input logic [15:0] d);
    da = a; ddat = d; dmw = 1'b1;
    step(1);
    dmw = 1'b0;
  endtask

  task automatic dmem_rd(input logic [10:0] a, output logic [15:0] d);
    da = a; dmr = 1'b1;
    #1 d = dout;
    dmr = 1'b0;
  endtask

  // Freeze, hold reset, upload prog[] (rest of imem zero), optionally clear dmem[0..15]
  task automatic load(input bit clr_dmem);
    enPC = 1'b0;
    rst  = 1'b0;
    step(1);
    for (int i = 0; i < 128; i++) imem_wr(7'(i), (i < 16) ? prog[i] : 32'h0);
    if (clr_dmem) for (int i = 0; i < 16; i++) dmem_wr(11'(i), 16'h0);
    rst = 1'b1;
    step(1);
  endtask

  task automatic fwd_prog();
    prog = '{default: 32'h0};
    prog[0] = enc_i(6'b001000, 5'd0, 5'd1, 16'd5);
    prog[1] = enc_i(6'b001000, 5'd0, 5'd2, 16'd3);
    prog[2] = enc_r(5'd1, 5'd2, 5'd3, 6'b100000);
    prog[3] = enc_r(5'd3, 5'd1, 5'd4, 6'b100010);
    prog[4] = enc_i(6'b101011, 5'd0, 5'd3, 16'd0);
    prog[5] = enc_i(6'b101011, 5'd0, 5'd4, 16'd1);
  endtask

  initial begin
    rst = 1'b0; enPC = 1'b0;
    ia = '0; idat = '0; imw = 1'b0; imr = 1'b0;
    da = '0; ddat = '0; dmw = 1'b0; dmr = 1'b0;
    step(2);

    // Host upload and readback
    imem_wr(7'd5, 32'hDEADBEEF);
    dmem_wr(11'd7, 16'h1234);
    ia = 7'd5; imr = 1'b1;
    #1 check("imem_rd", iout, 32'hDEADBEEF);
    imr = 1'b0;
    #1 check("imem_mr0", iout, 32'h0);
    dmem_rd(11'd7, rd16);
    check("dmem_rd", {16'h0, rd16}, 32'h1234);
    da = 11'd7;
    #1 check("dmem_mr0", {16'h0, dout}, 32'h0);
    step(1);

    // Load-use into store
    prog = '{default: 32'h0};
    prog[1] = enc_i(6'b100011, 5'd0, 5'd8, 16'd2);
    prog[2] = enc_i(6'b101011, 5'd0, 5'd8, 16'd1);
    load(1'b1);
    dmem_wr(11'd2, 16'd1);
    enPC = 1'b1; step(8); enPC = 1'b0;
    dmem_rd(11'd1, rd16); check("lu_store", {16'h0, rd16}, 32'd1);
    dmem_rd(11'd2, rd16); check("lu_src",   {16'h0, rd16}, 32'd1);

    // Forwarding chain
    fwd_prog();
    load(1'b1);
    enPC = 1'b1; step(15); enPC = 1'b0;
    dmem_rd(11'd0, rd16); check("fwd_add", {16'h0, rd16}, 32'd8);
    dmem_rd(11'd1, rd16); check("fwd_sub", {16'h0, rd16}, 32'd3);

    // Taken branch flushes two slots; not-taken branch falls through
    prog = '{default: 32'h0};
    prog[0] = enc_i(6'b001000, 5'd0, 5'd1, 16'd1);
    prog[1] = enc_i(6'b000100, 5'd1, 5'd1, 16'd2);
    prog[2] = enc_i(6'b001000, 5'd0, 5'd2, 16'd9);
    prog[4] = enc_i(6'b101011, 5'd0, 5'd2, 16'd3);
    prog[5] = enc_i(6'b101011, 5'd0, 5'd1, 16'd5);
    prog[6] = enc_i(6'b000100, 5'd1, 5'd0, 16'd1);
    prog[7] = enc_i(6'b001000, 5'd0, 5'd5, 16'd7);
    prog[8] = enc_i(6'b101011, 5'd0, 5'd5, 16'd6);
    load(1'b1);
    dmem_wr(11'd3, 16'h5555);
    enPC = 1'b1; step(20); enPC = 1'b0;
    dmem_rd(11'd3, rd16); check("br_flush",  {16'h0, rd16}, 32'd0);
    dmem_rd(11'd5, rd16); check("br_target", {16'h0, rd16}, 32'd1);
    dmem_rd(11'd6, rd16); check("br_ntaken", {16'h0, rd16}, 32'd7);

    // Freeze mid-program; host write while running must be ignored
    fwd_prog();
    load(1'b1);
    enPC = 1'b1;
    da = 11'd9; ddat = 16'hBEEF; dmw = 1'b1;
    step(1);
    dmw = 1'b0;
    step(2);
    enPC = 1'b0;
    step(5);
    check("frz_pc", {25'h0, dut.pc_q}, 32'd3);
    dmem_rd(11'd0, rd16); check("frz_dmem", {16'h0, rd16}, 32'd0);
    enPC = 1'b1; step(15); enPC = 1'b0;
    dmem_rd(11'd0, rd16); check("frz_add", {16'h0, rd16}, 32'd8);
    dmem_rd(11'd1, rd16); check("frz_sub", {16'h0, rd16}, 32'd3);
    dmem_rd(11'd9, rd16); check("run_mw_ign", {16'h0, rd16}, 32'd0);

    // Mid-run reset with a store sitting in EX/MEM
    prog = '{default: 32'h0};
    prog[0] = enc_i(6'b001000, 5'd0, 5'd1, 16'd5);
    prog[3] = enc_i(6'b101011, 5'd0, 5'd1, 16'd12);
    load(1'b0);
    dmem_wr(11'd12, 16'h0);
    enPC = 1'b1; step(6);
    check("rst_pre_rf", {16'h0, dut.rf_q[1]}, 32'd5);
    rst = 1'b0;
    #1 check("rst_pc", {25'h0, dut.pc_q}, 32'd0);
    check("rst_rf", {16'h0, dut.rf_q[1]}, 32'd0);
    step(2);
    enPC = 1'b0;
    dmem_rd(11'd12, rd16); check("rst_no_st", {16'h0, rd16}, 32'd0);
    dmem_rd(11'd0, rd16);  check("rst_dmem_kept", {16'h0, rd16}, 32'd8);
    ia = 7'd0; imr = 1'b1;
    #1 check("rst_imem_kept", iout, 32'h20010005);
    imr = 1'b0;
    rst = 1'b1;
    step(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
